dcache_nway: RTL

// - Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
// - Sits between the load/store unit (byte-masked, word-aligned requests) and main memory (whole-block transfers).
// - Generalises the direct-mapped cache: configurable ways, sets and block size, plus dirty-victim writeback.
// - Exposes hit/miss counters for performance bring-up.

---
 rtl/dcache_nway.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement.
// Lookup is combinational in IDLE; misses optionally write back a dirty victim, then fill the line.
module dcache_nway #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 32,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic                      write_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  input  logic [3:0]                mask_i,
  output logic [31:0]               rdata_o,
  output logic                      ready_o,
  output logic                      mem_valid_o,
  output logic                      mem_write_o,
  output logic [31:0]               mem_addr_o,
  output logic [32*BLOCK_WORDS-1:0] mem_wdata_o,
  input  logic [32*BLOCK_WORDS-1:0] mem_rdata_i,
  input  logic                      mem_ready_i,
  output logic [31:0]               hit_cnt_o,
  output logic [31:0]               miss_cnt_o
);

  localparam int unsigned WB  = $clog2(BLOCK_WORDS);
  localparam int unsigned WBW = (WB > 0) ? WB : 1;
  localparam int unsigned OFF = WB + 2;
  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TAG = 32 - IDX - OFF;
  localparam int unsigned AW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LW  = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic            r_valid [WAYS][SETS];
  logic            r_dirty [WAYS][SETS];
  logic [TAG-1:0]  r_tag   [WAYS][SETS];
  logic [LW-1:0]   r_data  [WAYS][SETS];
  logic [AW-1:0]   r_age   [SETS][WAYS];

  logic [AW-1:0]   r_victim;
  logic            r_refill;
  logic            r_mem_valid;
  logic            r_mem_write;
  logic [31:0]     r_hit_cnt;
  logic [31:0]     r_miss_cnt;

  logic [IDX-1:0]  w_idx;
  logic [TAG-1:0]  w_tag;
  logic [WBW-1:0]  w_word;
  logic            w_hit;
  logic [AW-1:0]   w_hit_way;
  logic [31:0]     w_hit_word;
  logic [AW-1:0]   w_victim;
  logic            w_found;
  logic            w_victim_dirty;
  logic            w_miss;

  always_comb begin
    w_idx  = addr_i[OFF+IDX-1:OFF];
    w_tag  = addr_i[31:OFF+IDX];
    w_word = WBW'(addr_i[OFF-1:0] >> 2);
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AW'(w);
      end
    end
    w_hit_word = r_data[w_hit_way][w_idx][{w_word, 5'b0} +: 32];
  end

  // Prefer the lowest invalid way; otherwise the oldest (age WAYS-1) way.
  always_comb begin
    w_victim = '0;
    w_found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_found && !r_valid[w][w_idx]) begin
        w_found  = 1'b1;
        w_victim = AW'(w);
      end
    end
    if (!w_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (r_age[w_idx][w] == AW'(WAYS - 1)) begin
          w_victim = AW'(w);
        end
      end
    end
    w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
  end

  always_comb begin
    w_next      = r_state;
    ready_o     = 1'b0;
    rdata_o     = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    w_miss      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i && !rst_i) begin
          if (w_hit) begin
            ready_o = 1'b1;
            rdata_o = w_hit_word;
          end else begin
            w_miss = 1'b1;
            w_next = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        mem_addr_o  = {r_tag[r_victim][w_idx], w_idx, {OFF{1'b0}}};
        mem_wdata_o = r_data[r_victim][w_idx];
        if (mem_ready_i) begin
          w_next = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        mem_addr_o = {w_tag, w_idx, {OFF{1'b0}}};
        if (mem_ready_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_valid_o = r_mem_valid;
    mem_write_o = r_mem_write;
    hit_cnt_o   = r_hit_cnt;
    miss_cnt_o  = r_miss_cnt;
  end

  // The post-fill re-lookup completes the original miss, so it is not counted as a hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_write <= 1'b0;
      r_victim    <= '0;
      r_refill    <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
          r_age[s][w]   <= AW'(w);
        end
      end
    end else begin
      r_state     <= w_next;
      r_mem_valid <= (w_next != S_IDLE);
      r_mem_write <= (w_next == S_WRITEBACK);
      if (r_state == S_IDLE) begin
        r_refill <= 1'b0;
      end
      if (ready_o) begin
        if (write_i && (mask_i != 4'b0000)) begin
          r_dirty[w_hit_way][w_idx] <= 1'b1;
        end
        if (!r_refill && (r_hit_cnt != '1)) begin
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end
        if (WAYS > 1) begin
          for (int unsigned v = 0; v < WAYS; v++) begin
            if (r_age[w_idx][v] < r_age[w_idx][w_hit_way]) begin
              r_age[w_idx][v] <= r_age[w_idx][v] + 1'b1;
            end
          end
          r_age[w_idx][w_hit_way] <= '0;
        end
      end
      if (w_miss) begin
        r_victim <= w_victim;
        if (r_miss_cnt != '1) begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
      if ((r_state == S_ALLOCATE) && mem_ready_i) begin
        r_valid[r_victim][w_idx] <= 1'b1;
        r_dirty[r_victim][w_idx] <= 1'b0;
        r_refill                 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ready_o && write_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mask_i[b]) begin
          r_data[w_hit_way][w_idx][{w_word, 5'b0} + 8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (!rst_i && (r_state == S_ALLOCATE) && mem_ready_i) begin
      r_data[r_victim][w_idx] <= mem_rdata_i;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

endmodule
